// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage.
//   - ALU opcode encodings
//   - multiply FSM state encoding
//   - operand-forwarding select encoding
//   - EXE/MEM control bundle
package exe_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic wen;
  } ctrl_t;

endpackage

// File: rtl/exe_stage_seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : accepted only in IDLE; latches a_i/b_i
//   a_i, b_i   : operands
//   busy_o     : high for DSIZE cycles while accumulating
//   done_o     : high for one cycle; product_o valid
//   product_o  : low DSIZE bits of a*b
module seq_multiplier
  import exe_pkg::*;
#(
  parameter int DSIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DSIZE-1:0] a_i,
  input  logic [DSIZE-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DSIZE-1:0] product_o
);

  localparam int CW = $clog2(DSIZE);

  mul_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DSIZE-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // partial products above bit DSIZE-1 fall off: result wraps
        if (b_q[cnt_q]) acc_d = acc_q + (a_q << cnt_q);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DSIZE - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o    = (state_q == ST_BUSY);
  assign done_o    = (state_q == ST_DONE);
  assign product_o = acc_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU, branch/jal resolution,
// iterative MUL with front-end stall, and the EXE/MEM pipeline register.
//   Inputs : ID/EXE bundle (rdata*, imm, opcode, controls, npc),
//            EXE/MEM and MEM/WB forwarding sources
//   Outputs: stall_out, branch_taken_out/branch_target_out (combinational),
//            registered EXE/MEM bundle (alu/wdata/waddr + controls)
module exe_stage
  import exe_pkg::*;
#(
  parameter int DSIZE = 16,
  parameter int ASIZE = 5,
  parameter int ISIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] rdata1_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [DSIZE-1:0] imm_in,
  input  logic [2:0]       opcode_in,
  input  logic             alusrc_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic [ASIZE-1:0] rs1_in,
  input  logic [ASIZE-1:0] rs2_in,
  input  logic             memWrite_in,
  input  logic             memRead_in,
  input  logic             memToReg_in,
  input  logic             WriteEn_in,
  input  logic             branch_in,
  input  logic             jal_in,
  input  logic [ISIZE-1:0] npc_in,
  input  logic             exmem_wen_fwd,
  input  logic [ASIZE-1:0] exmem_waddr_fwd,
  input  logic [DSIZE-1:0] exmem_data_fwd,
  input  logic             memwb_wen_fwd,
  input  logic [ASIZE-1:0] memwb_waddr_fwd,
  input  logic [DSIZE-1:0] memwb_data_fwd,
  output logic             stall_out,
  output logic             branch_taken_out,
  output logic [ISIZE-1:0] branch_target_out,
  output logic [DSIZE-1:0] alu_out,
  output logic [DSIZE-1:0] wdata_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             memWrite_out,
  output logic             memRead_out,
  output logic             memToReg_out,
  output logic             WriteEn_out
);

  localparam int SHW = $clog2(DSIZE);

  fwd_sel_e         sel_a, sel_b;
  logic [DSIZE-1:0] fwd_a, fwd_b, op_b, alu_res;
  ctrl_t            ctrl_in;

  // ---------------- forwarding ----------------
  always_comb begin
    sel_a = FWD_NONE;
    sel_b = FWD_NONE;
    if (exmem_wen_fwd && (exmem_waddr_fwd != '0) && (exmem_waddr_fwd == rs1_in))
      sel_a = FWD_EXMEM;
    else if (memwb_wen_fwd && (memwb_waddr_fwd != '0) && (memwb_waddr_fwd == rs1_in))
      sel_a = FWD_MEMWB;
    if (exmem_wen_fwd && (exmem_waddr_fwd != '0) && (exmem_waddr_fwd == rs2_in))
      sel_b = FWD_EXMEM;
    else if (memwb_wen_fwd && (memwb_waddr_fwd != '0) && (memwb_waddr_fwd == rs2_in))
      sel_b = FWD_MEMWB;
  end

  always_comb begin
    case (sel_a)
      FWD_EXMEM: fwd_a = exmem_data_fwd;
      FWD_MEMWB: fwd_a = memwb_data_fwd;
      default:   fwd_a = rdata1_in;
    endcase
    case (sel_b)
      FWD_EXMEM: fwd_b = exmem_data_fwd;
      FWD_MEMWB: fwd_b = memwb_data_fwd;
      default:   fwd_b = rdata2_in;
    endcase
  end

  assign op_b = alusrc_in ? imm_in : fwd_b;

  // ---------------- ALU ----------------
  always_comb begin
    alu_res = '0;
    case (opcode_in)
      OP_ADD: alu_res = fwd_a + op_b;
      OP_SUB: alu_res = fwd_a - op_b;
      OP_AND: alu_res = fwd_a & op_b;
      OP_OR:  alu_res = fwd_a | op_b;
      OP_XOR: alu_res = fwd_a ^ op_b;
      OP_SLL: alu_res = fwd_a << op_b[SHW-1:0];
      OP_SLT: alu_res = {{(DSIZE-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      default: alu_res = '0;  // MUL result comes from the multiplier
    endcase
  end

  // ---------------- multiply ----------------
  logic             mul_busy, mul_done, mul_start;
  logic [DSIZE-1:0] mul_prod;
  ctrl_t            mctrl_q;
  logic [ASIZE-1:0] mwaddr_q;
  logic [DSIZE-1:0] mwdata_q;

  // No start in DONE: the same MUL is still sitting in ID/EXE that cycle.
  assign mul_start = (opcode_in == OP_MUL) && !mul_busy && !mul_done;
  assign stall_out = mul_start || mul_busy;

  seq_multiplier #(.DSIZE(DSIZE)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (fwd_a),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  assign ctrl_in = '{mem_write: memWrite_in, mem_read: memRead_in,
                     mem_to_reg: memToReg_in, wen: WriteEn_in};

  // Forwarding sources drain during the stall, so capture everything at start.
  always_ff @(posedge clk) begin
    if (rst) begin
      mctrl_q  <= '0;
      mwaddr_q <= '0;
      mwdata_q <= '0;
    end else if (mul_start) begin
      mctrl_q  <= ctrl_in;
      mwaddr_q <= waddr_in;
      mwdata_q <= fwd_b;
    end
  end

  // ---------------- branch / jal ----------------
  assign branch_taken_out  = !stall_out && (jal_in || (branch_in && (fwd_a == fwd_b)));
  assign branch_target_out = npc_in + ISIZE'(imm_in);

  // ---------------- EXE/MEM register ----------------
  logic [DSIZE-1:0] alu_q, alu_d, wdata_q, wdata_d;
  logic [ASIZE-1:0] waddr_q, waddr_d;
  ctrl_t            ctrl_q, ctrl_d;

  always_comb begin
    alu_d   = '0;
    wdata_d = '0;
    waddr_d = '0;
    ctrl_d  = '0;  // bubble while stalled
    if (!stall_out) begin
      if (mul_done) begin
        alu_d   = mul_prod;
        wdata_d = mwdata_q;
        waddr_d = mwaddr_q;
        ctrl_d  = mctrl_q;
      end else begin
        alu_d   = jal_in ? DSIZE'(npc_in) : alu_res;
        wdata_d = fwd_b;
        waddr_d = waddr_in;
        ctrl_d  = ctrl_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q   <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      ctrl_q  <= '0;
    end else begin
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign alu_out      = alu_q;
  assign wdata_out    = wdata_q;
  assign waddr_out    = waddr_q;
  assign memWrite_out = ctrl_q.mem_write;
  assign memRead_out  = ctrl_q.mem_read;
  assign memToReg_out = ctrl_q.mem_to_reg;
  assign WriteEn_out  = ctrl_q.wen;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
  localparam int DSIZE = 16;
  localparam int ASIZE = 5;
  localparam int ISIZE = 16;

  logic clk = 0, rst;
  logic [DSIZE-1:0] rdata1_in, rdata2_in, imm_in;
  logic [2:0] opcode_in;
  logic alusrc_in;
  logic [ASIZE-1:0] waddr_in, rs1_in, rs2_in;
  logic memWrite_in, memRead_in, memToReg_in, WriteEn_in, branch_in, jal_in;
  logic [ISIZE-1:0] npc_in;
  logic exmem_wen_fwd, memwb_wen_fwd;
  logic [ASIZE-1:0] exmem_waddr_fwd, memwb_waddr_fwd;
  logic [DSIZE-1:0] exmem_data_fwd, memwb_data_fwd;
  logic stall_out, branch_taken_out;
  logic [ISIZE-1:0] branch_target_out;
  logic [DSIZE-1:0] alu_out, wdata_out;
  logic [ASIZE-1:0] waddr_out;
  logic memWrite_out, memRead_out, memToReg_out, WriteEn_out;

  exe_stage #(.DSIZE(DSIZE), .ASIZE(ASIZE), .ISIZE(ISIZE)) dut (
    .clk(clk), .rst(rst),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .opcode_in(opcode_in), .alusrc_in(alusrc_in), .waddr_in(waddr_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in),
    .memWrite_in(memWrite_in), .memRead_in(memRead_in), .memToReg_in(memToReg_in),
    .WriteEn_in(WriteEn_in), .branch_in(branch_in), .jal_in(jal_in), .npc_in(npc_in),
    .exmem_wen_fwd(exmem_wen_fwd), .exmem_waddr_fwd(exmem_waddr_fwd),
    .exmem_data_fwd(exmem_data_fwd),
    .memwb_wen_fwd(memwb_wen_fwd), .memwb_waddr_fwd(memwb_waddr_fwd),
    .memwb_data_fwd(memwb_data_fwd),
    .stall_out(stall_out), .branch_taken_out(branch_taken_out),
    .branch_target_out(branch_target_out),
    .alu_out(alu_out), .wdata_out(wdata_out), .waddr_out(waddr_out),
    .memWrite_out(memWrite_out), .memRead_out(memRead_out),
    .memToReg_out(memToReg_out), .WriteEn_out(WriteEn_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_on/m_k: a MUL is in flight, m_k = cycles since it was accepted.
  // Stalled for the accept cycle plus DSIZE more; cycle DSIZE+1 writes back.
  bit m_on = 0;
  int m_k = 0;
  bit m_prev_stall = 0;
  logic [DSIZE-1:0] m_alu = 0, m_wdata = 0, l_prod = 0, l_wdata = 0;
  logic [ASIZE-1:0] m_waddr = 0, l_waddr = 0;
  logic [3:0] m_ctl = 0, l_ctl = 0;  // {memWrite, memRead, memToReg, WriteEn}

  function automatic logic [DSIZE-1:0] fwdv(input logic [ASIZE-1:0] rs, input logic [DSIZE-1:0] d);
    if (rs != 0 && exmem_wen_fwd && exmem_waddr_fwd == rs) return exmem_data_fwd;
    if (rs != 0 && memwb_wen_fwd && memwb_waddr_fwd == rs) return memwb_data_fwd;
    return d;
  endfunction

  function automatic logic [DSIZE-1:0] aluv(input logic [2:0] op, input logic [DSIZE-1:0] a, b);
    longint r;
    logic signed [DSIZE-1:0] sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: r = longint'(a) + longint'(b);
      3'd1: r = longint'(a) - longint'(b);
      3'd2: r = longint'(a & b);
      3'd3: r = longint'(a | b);
      3'd4: r = longint'(a ^ b);
      3'd5: r = longint'(a) << (b % DSIZE);
      3'd6: r = longint'(a) * longint'(b);
      default: r = (sa < sb) ? 1 : 0;
    endcase
    return r[DSIZE-1:0];
  endfunction

  function automatic bit mstall();
    return m_on ? (m_k <= DSIZE) : (opcode_in == 3'd6);
  endfunction

  always @(posedge clk) begin
    logic [DSIZE-1:0] fa, fb, ob;
    fa = fwdv(rs1_in, rdata1_in);
    fb = fwdv(rs2_in, rdata2_in);
    ob = alusrc_in ? imm_in : fb;
    m_prev_stall = mstall();
    if (rst) begin
      m_on = 0; m_alu = 0; m_wdata = 0; m_waddr = 0; m_ctl = 0;
    end else if (m_on && m_k <= DSIZE) begin
      m_k++; m_alu = 0; m_wdata = 0; m_waddr = 0; m_ctl = 0;
    end else if (m_on) begin
      m_on = 0; m_alu = l_prod; m_wdata = l_wdata; m_waddr = l_waddr; m_ctl = l_ctl;
    end else if (opcode_in == 3'd6) begin
      m_on = 1; m_k = 1;
      l_prod = aluv(3'd6, fa, ob); l_wdata = fb; l_waddr = waddr_in;
      l_ctl = {memWrite_in, memRead_in, memToReg_in, WriteEn_in};
      m_alu = 0; m_wdata = 0; m_waddr = 0; m_ctl = 0;
    end else begin
      m_alu = jal_in ? DSIZE'(npc_in) : aluv(opcode_in, fa, ob);
      m_wdata = fb; m_waddr = waddr_in;
      m_ctl = {memWrite_in, memRead_in, memToReg_in, WriteEn_in};
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      logic [DSIZE-1:0] fa, fb;
      bit st, tk;
      fa = fwdv(rs1_in, rdata1_in);
      fb = fwdv(rs2_in, rdata2_in);
      st = mstall();
      tk = !st && (jal_in || (branch_in && fa == fb));
      chk("stall", stall_out, st);
      chk("taken", branch_taken_out, tk);
      chk("target", branch_target_out, ISIZE'(npc_in + ISIZE'(imm_in)));
      chk("alu_out", alu_out, m_alu);
      chk("wdata_out", wdata_out, m_wdata);
      chk("waddr_out", waddr_out, m_waddr);
      chk("ctl_out", {memWrite_out, memRead_out, memToReg_out, WriteEn_out}, m_ctl);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_nop();
    rdata1_in = 0; rdata2_in = 0; imm_in = 0; opcode_in = 3'd0; alusrc_in = 0;
    waddr_in = 0; rs1_in = 0; rs2_in = 0;
    memWrite_in = 0; memRead_in = 0; memToReg_in = 0; WriteEn_in = 0;
    branch_in = 0; jal_in = 0; npc_in = 0;
    exmem_wen_fwd = 0; exmem_waddr_fwd = 0; exmem_data_fwd = 0;
    memwb_wen_fwd = 0; memwb_waddr_fwd = 0; memwb_data_fwd = 0;
  endtask

  task automatic run_mul(input logic [DSIZE-1:0] a, b, input logic [DSIZE-1:0] exp, input string nm);
    int cnt;
    set_nop();
    opcode_in = 3'd6; rs1_in = 1; rs2_in = 2; rdata1_in = a; rdata2_in = b;
    WriteEn_in = 1; waddr_in = 9;
    #1;
    cnt = 0;
    for (int i = 0; i < 40 && stall_out; i++) begin
      cnt++;
      tick();
      chk({nm, "_bubble"}, {memWrite_out, memRead_out, memToReg_out, WriteEn_out}, 4'b0000);
    end
    chk({nm, "_stall_cycles"}, cnt, DSIZE + 1);
    tick();  // DONE edge: MUL still in ID/EXE, must not restart
    set_nop();
    chk({nm, "_product"}, alu_out, exp);
    chk({nm, "_wen"}, WriteEn_out, 1);
    chk({nm, "_waddr"}, waddr_out, 9);
    #1;
    chk({nm, "_no_retrigger"}, stall_out, 0);
  endtask

  task automatic rand_instr();
    opcode_in = 3'($urandom_range(0, 7));
    rdata1_in = DSIZE'($urandom); rdata2_in = DSIZE'($urandom); imm_in = DSIZE'($urandom);
    alusrc_in = 1'($urandom); waddr_in = ASIZE'($urandom);
    rs1_in = ASIZE'($urandom_range(0, 3)); rs2_in = ASIZE'($urandom_range(0, 3));
    {memWrite_in, memRead_in, memToReg_in, WriteEn_in} = 4'($urandom);
    npc_in = ISIZE'($urandom);
    branch_in = ($urandom_range(0, 5) == 0);
    jal_in = !branch_in && ($urandom_range(0, 7) == 0);
    if (branch_in && $urandom_range(0, 1) == 1) rdata2_in = rdata1_in;
    if (opcode_in == 3'd6) begin branch_in = 0; jal_in = 0; end
  endtask

  initial begin
    set_nop();
    rst = 1;
    tick();
    started = 1;
    tick();
    chk("rst_alu", alu_out, 0);
    chk("rst_wen", WriteEn_out, 0);
    chk("rst_stall", stall_out, 0);
    rst = 0;

    // EXE/MEM wins over MEM/WB
    set_nop();
    rs1_in = 3; rs2_in = 1; rdata1_in = 5; rdata2_in = 1; WriteEn_in = 1; waddr_in = 7;
    exmem_wen_fwd = 1; exmem_waddr_fwd = 3; exmem_data_fwd = 16'h0010;
    memwb_wen_fwd = 1; memwb_waddr_fwd = 3; memwb_data_fwd = 16'h0020;
    tick();
    chk("fwd_priority", alu_out, 16'h0011);

    // r0 never forwarded
    set_nop();
    rs1_in = 0; rs2_in = 5; rdata1_in = 2; rdata2_in = 3;
    exmem_wen_fwd = 1; exmem_waddr_fwd = 0; exmem_data_fwd = 16'hFFFF;
    tick();
    chk("r0_nofwd", alu_out, 16'h0005);

    run_mul(16'h0003, 16'h0005, 16'h000F, "mul_3x5");
    run_mul(16'h8001, 16'h0002, 16'h0002, "mul_wrap");

    // branch taken / not taken
    set_nop();
    branch_in = 1; rs1_in = 1; rs2_in = 2; rdata1_in = 7; rdata2_in = 7;
    npc_in = 16'h0010; imm_in = 16'hFFFC;
    #1;
    chk("beq_taken", branch_taken_out, 1);
    chk("beq_target", branch_target_out, 16'h000C);
    rdata2_in = 8;
    #1;
    chk("bne_taken", branch_taken_out, 0);
    tick();

    // jal
    set_nop();
    jal_in = 1; npc_in = 16'h0021; imm_in = 16'h0004; WriteEn_in = 1; waddr_in = 1;
    #1;
    chk("jal_taken", branch_taken_out, 1);
    chk("jal_target", branch_target_out, 16'h0025);
    tick();
    chk("jal_link", alu_out, 16'h0021);

    // reset in the 5th BUSY cycle
    set_nop();
    opcode_in = 3'd6; rdata1_in = 3; rdata2_in = 5; WriteEn_in = 1; waddr_in = 4;
    #1;
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    set_nop();
    #1;
    chk("rstmul_stall", stall_out, 0);
    chk("rstmul_alu", alu_out, 0);
    chk("rstmul_wen", WriteEn_out, 0);
    rdata1_in = 2; rdata2_in = 3; WriteEn_in = 1; waddr_in = 6;
    tick();
    chk("rstmul_add", alu_out, 16'h0005);
    chk("rstmul_add_wen", WriteEn_out, 1);

    // randomized: ID/EXE only advances when the stage did not stall
    set_nop();
    for (int c = 0; c < 2000; c++) begin
      if (!m_prev_stall) rand_instr();
      exmem_wen_fwd = 1'($urandom); exmem_waddr_fwd = ASIZE'($urandom_range(0, 3));
      exmem_data_fwd = DSIZE'($urandom);
      memwb_wen_fwd = 1'($urandom); memwb_waddr_fwd = ASIZE'($urandom_range(0, 3));
      memwb_data_fwd = DSIZE'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
